// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bus of the MEM-stage load/store unit.
// master = pipeline plus memory side, slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] ALUResult;
    logic [31:0] WriteWord;
    logic [7:0]  WriteByte;
    logic [1:0]  Write_EN;
    logic [31:0] Read_Data;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, Read_Data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ALUResult, WriteWord, WriteByte, Write_EN
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, Read_Data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ALUResult, WriteWord, WriteByte, Write_EN
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store sequencer for the Mem_Datos port: one request per handshake,
// SH split into two byte writes, loads extended and returned on a one-cycle pulse.
module lsu_mem_ctrl #(
    parameter int unsigned READ_LAT = 1
) (
    input logic           CLK,
    input logic           RST,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ST_WORD, ST_LO, ST_HI, RD_WAIT, RESP} state_t;

    state_t      state_q, state_n;
    logic [2:0]  cnt_q, cnt_n;
    logic [2:0]  f3_q, f3_n;
    logic [7:0]  hi_q, hi_n;
    logic [31:0] rdata_q, rdata_n;
    logic        err_q, err_n;

    logic        ready_n, rsp_valid_n, rsp_err_n;
    logic [31:0] rsp_rdata_n, addr_n, wword_n;
    logic [7:0]  wbyte_n;
    logic [1:0]  we_n;
    logic        legal;
    logic [31:0] ext;

    always_comb begin
        if (bus.req_store) legal = (bus.req_funct3 <= 3'd2);
        else               legal = (bus.req_funct3 != 3'd3) && (bus.req_funct3 < 3'd6);
    end

    always_comb begin
        case (f3_q)
            3'd0:    ext = {{24{bus.Read_Data[7]}}, bus.Read_Data[7:0]};
            3'd1:    ext = {{16{bus.Read_Data[15]}}, bus.Read_Data[15:0]};
            3'd4:    ext = {24'h0, bus.Read_Data[7:0]};
            3'd5:    ext = {16'h0, bus.Read_Data[15:0]};
            default: ext = bus.Read_Data;
        endcase
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        f3_n        = f3_q;
        hi_n        = hi_q;
        rdata_n     = rdata_q;
        err_n       = err_q;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = bus.rsp_rdata;
        addr_n      = bus.ALUResult;
        wword_n     = bus.WriteWord;
        wbyte_n     = bus.WriteByte;
        we_n        = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    f3_n    = bus.req_funct3;
                    hi_n    = bus.req_wdata[15:8];
                    rdata_n = '0;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    if (!legal) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else if (bus.req_store) begin
                        addr_n = bus.req_addr;
                        if (bus.req_funct3 == 3'd2) begin
                            state_n = ST_WORD;
                            wword_n = bus.req_wdata;
                            we_n    = 2'd1;
                        end else begin
                            state_n = ST_LO;
                            wbyte_n = bus.req_wdata[7:0];
                            we_n    = 2'd2;
                        end
                    end else begin
                        addr_n  = bus.req_addr;
                        state_n = RD_WAIT;
                    end
                end
            end
            ST_WORD: state_n = RESP;
            ST_LO: begin
                // SH: second byte goes to the next address, wrapping at 2^32
                if (f3_q == 3'd1) begin
                    state_n = ST_HI;
                    addr_n  = bus.ALUResult + 32'd1;
                    wbyte_n = hi_q;
                    we_n    = 2'd2;
                end else begin
                    state_n = RESP;
                end
            end
            ST_HI: state_n = RESP;
            RD_WAIT: begin
                if (cnt_q == 3'(READ_LAT)) begin
                    rdata_n = ext;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end
            RESP: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = rdata_q;
                rsp_err_n   = err_q;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            f3_q          <= '0;
            hi_q          <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.ALUResult <= '0;
            bus.WriteWord <= '0;
            bus.WriteByte <= '0;
            bus.Write_EN  <= '0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            f3_q          <= f3_n;
            hi_q          <= hi_n;
            rdata_q       <= rdata_n;
            err_q         <= err_n;
            bus.req_ready <= ready_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_err   <= rsp_err_n;
            bus.rsp_rdata <= rsp_rdata_n;
            bus.ALUResult <= addr_n;
            bus.WriteWord <= wword_n;
            bus.WriteByte <= wbyte_n;
            bus.Write_EN  <= we_n;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (READ_LAT 1 and 3), each with a byte-array
// memory on its bus, checked against a byte-level reference of RV32I store/load semantics.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus1();
    lsu_mem_ctrl_if bus3();

    lsu_mem_ctrl #(.READ_LAT(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
    lsu_mem_ctrl #(.READ_LAT(3)) dut3 (.CLK(clk), .RST(rst), .bus(bus3));

    int n_cmp = 0;
    int n_bad = 0;

    int          sel   = 0;
    logic        vld   = 1'b0;
    logic        st    = 1'b0;
    logic [2:0]  f3    = 3'd0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] last_rdata;

    assign bus1.req_valid  = vld && (sel == 0);
    assign bus3.req_valid  = vld && (sel == 1);
    assign bus1.req_store  = st;
    assign bus3.req_store  = st;
    assign bus1.req_funct3 = f3;
    assign bus3.req_funct3 = f3;
    assign bus1.req_addr   = addr;
    assign bus3.req_addr   = addr;
    assign bus1.req_wdata  = wdata;
    assign bus3.req_wdata  = wdata;

    logic        o_ready, o_rsp_valid, o_err;
    logic [31:0] o_rdata, o_addr, o_wword;
    logic [7:0]  o_wbyte;
    logic [1:0]  o_we;
    assign o_ready     = (sel == 1) ? bus3.req_ready : bus1.req_ready;
    assign o_rsp_valid = (sel == 1) ? bus3.rsp_valid : bus1.rsp_valid;
    assign o_err       = (sel == 1) ? bus3.rsp_err   : bus1.rsp_err;
    assign o_rdata     = (sel == 1) ? bus3.rsp_rdata : bus1.rsp_rdata;
    assign o_addr      = (sel == 1) ? bus3.ALUResult : bus1.ALUResult;
    assign o_wword     = (sel == 1) ? bus3.WriteWord : bus1.WriteWord;
    assign o_wbyte     = (sel == 1) ? bus3.WriteByte : bus1.WriteByte;
    assign o_we        = (sel == 1) ? bus3.Write_EN  : bus1.Write_EN;

    // Memories seen by each DUT, and the reference contents each should hold.
    bit [7:0] mem1 [bit [31:0]];
    bit [7:0] mem3 [bit [31:0]];
    bit [7:0] ref1 [bit [31:0]];
    bit [7:0] ref3 [bit [31:0]];

    function automatic logic [7:0] mem_rd(input int s, input logic [31:0] a);
        if (s == 1) return mem3.exists(a) ? mem3[a] : 8'h00;
        return mem1.exists(a) ? mem1[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input int s, input logic [31:0] a);
        if (s == 1) return ref3.exists(a) ? ref3[a] : 8'h00;
        return ref1.exists(a) ? ref1[a] : 8'h00;
    endfunction

    function automatic void ref_wr(input int s, input logic [31:0] a, input logic [7:0] d);
        if (s == 1) ref3[a] = d;
        else        ref1[a] = d;
    endfunction

    function automatic logic [31:0] ref_load(input int s, input logic [2:0] fn, input logic [31:0] a);
        logic [31:0] w;
        int v;
        w = {ref_rd(s, a + 32'd3), ref_rd(s, a + 32'd2), ref_rd(s, a + 32'd1), ref_rd(s, a)};
        case (fn)
            3'd0: begin v = int'(w[7:0]);  if (v > 127)   v = v - 256;   return 32'(v); end
            3'd1: begin v = int'(w[15:0]); if (v > 32767) v = v - 65536; return 32'(v); end
            3'd4: return 32'(int'(w[7:0]));
            3'd5: return 32'(int'(w[15:0]));
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus1.Write_EN == 2'd1)
            for (int i = 0; i < 4; i++) mem1[bus1.ALUResult + 32'(i)] = bus1.WriteWord[8*i +: 8];
        else if (bus1.Write_EN == 2'd2)
            mem1[bus1.ALUResult] = bus1.WriteByte;
        if (bus3.Write_EN == 2'd1)
            for (int i = 0; i < 4; i++) mem3[bus3.ALUResult + 32'(i)] = bus3.WriteWord[8*i +: 8];
        else if (bus3.Write_EN == 2'd2)
            mem3[bus3.ALUResult] = bus3.WriteByte;
    end

    always @(negedge clk) begin
        bus1.Read_Data = {mem_rd(0, bus1.ALUResult + 32'd3), mem_rd(0, bus1.ALUResult + 32'd2),
                          mem_rd(0, bus1.ALUResult + 32'd1), mem_rd(0, bus1.ALUResult)};
        bus3.Read_Data = {mem_rd(1, bus3.ALUResult + 32'd3), mem_rd(1, bus3.ALUResult + 32'd2),
                          mem_rd(1, bus3.ALUResult + 32'd1), mem_rd(1, bus3.ALUResult)};
    end

    // One request on instance s; checks memory-side cycles, latency and response.
    task automatic do_req(input int s, input logic is_st, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] wd);
        bit legal, seen;
        int lat, n, en_exp, nbytes;
        logic [31:0] exp_rd;
        legal  = is_st ? (fn < 3'd3) : (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        lat    = !legal ? 1 : is_st ? ((fn == 3'd1) ? 3 : 2) : ((s == 1) ? 3 : 1) + 2;
        exp_rd = (legal && !is_st) ? ref_load(s, fn, a) : 32'h0;
        sel = s; st = is_st; f3 = fn; addr = a; wdata = wd; vld = 1'b1;
        #1;
        n = 0;
        while (!o_ready && n < 20) begin @(negedge clk); n++; end
        if (!o_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", o_ready, n);
            vld = 1'b0;
            return;
        end
        @(posedge clk); #1 vld = 1'b0;
        seen = 0;
        for (int j = 0; j < 16 && !seen; j++) begin
            @(negedge clk);
            en_exp = 0;
            if (legal && is_st) begin
                if (fn == 3'd2) en_exp = (j == 0) ? 1 : 0;
                else            en_exp = (j == 0 || (fn == 3'd1 && j == 1)) ? 2 : 0;
            end
            n_cmp++;
            if (o_we !== 2'(en_exp)) begin
                n_bad++;
                $display("FAIL write_en f3=%0d st=%0b j=%0d: got %0d required %0d", fn, is_st, j, o_we, en_exp);
            end
            if (en_exp != 0) begin
                n_cmp++;
                if (o_addr !== a + 32'(j)) begin
                    n_bad++;
                    $display("FAIL mem_addr j=%0d: got %h required %h", j, o_addr, a + 32'(j));
                end
                n_cmp++;
                if (en_exp == 1 && o_wword !== wd) begin
                    n_bad++;
                    $display("FAIL write_word: got %h required %h", o_wword, wd);
                end else if (en_exp == 2 && o_wbyte !== wd[8*j +: 8]) begin
                    n_bad++;
                    $display("FAIL write_byte j=%0d: got %h required %h", j, o_wbyte, wd[8*j +: 8]);
                end
            end
            if (o_rsp_valid === 1'b1) begin
                seen = 1;
                last_rdata = o_rdata;
                n_cmp++;
                if (j != lat) begin
                    n_bad++;
                    $display("FAIL latency f3=%0d st=%0b dut%0d: got %0d required %0d", fn, is_st, s, j, lat);
                end
                n_cmp++;
                if (o_rdata !== exp_rd) begin
                    n_bad++;
                    $display("FAIL rsp_rdata f3=%0d addr=%h: got %h required %h", fn, a, o_rdata, exp_rd);
                end
                n_cmp++;
                if (o_err !== !legal) begin
                    n_bad++;
                    $display("FAIL rsp_err f3=%0d st=%0b: got %0b required %0b", fn, is_st, o_err, !legal);
                end
                n_cmp++;
                if (o_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ready_at_rsp: got %0b required 1", o_ready);
                end
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout f3=%0d st=%0b: no rsp_valid, required one at %0d", fn, is_st, lat);
        end else begin
            @(negedge clk);
            n_cmp++;
            if (o_rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rsp_pulse: rsp_valid=%0b one cycle later, required 0", o_rsp_valid);
            end
        end
        if (legal && is_st) begin
            nbytes = (fn == 3'd0) ? 1 : (fn == 3'd1) ? 2 : 4;
            for (int i = 0; i < nbytes; i++) ref_wr(s, a + 32'(i), wd[8*i +: 8]);
        end
    endtask

    task automatic test_reset();
        logic [108:0] exp_v;
        exp_v = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h0, 2'h0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata, bus1.ALUResult,
             bus1.WriteWord, bus1.WriteByte, bus1.Write_EN} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_dut1: rdy=%b v=%b e=%b rd=%h a=%h ww=%h wb=%h en=%0d, required rdy=1 rest 0",
                     bus1.req_ready, bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata, bus1.ALUResult,
                     bus1.WriteWord, bus1.WriteByte, bus1.Write_EN);
        end
        n_cmp++;
        if ({bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata, bus3.ALUResult,
             bus3.WriteWord, bus3.WriteByte, bus3.Write_EN} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_dut3: rdy=%b v=%b e=%b rd=%h a=%h en=%0d, required rdy=1 rest 0",
                     bus3.req_ready, bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata, bus3.ALUResult, bus3.Write_EN);
        end
    endtask

    task automatic test_stores_loads();
        do_req(0, 1'b1, 3'd2, 32'h0000_0001, 32'h0000_0002);
        do_req(0, 1'b1, 3'd0, 32'h0000_FFFF, 32'h0000_00AA);
        do_req(0, 1'b0, 3'd4, 32'h0000_FFFF, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'h0000_00AA) begin
            n_bad++; $display("FAIL lbu_const: got %h required 000000aa", last_rdata);
        end
        do_req(0, 1'b0, 3'd0, 32'h0000_FFFF, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'hFFFF_FFAA) begin
            n_bad++; $display("FAIL lb_const: got %h required ffffffaa", last_rdata);
        end
        do_req(0, 1'b1, 3'd1, 32'h0000_0010, 32'h0000_8899);
        do_req(0, 1'b0, 3'd1, 32'h0000_0010, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'hFFFF_8899) begin
            n_bad++; $display("FAIL lh_const: got %h required ffff8899", last_rdata);
        end
        do_req(0, 1'b0, 3'd5, 32'h0000_0010, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'h0000_8899) begin
            n_bad++; $display("FAIL lhu_const: got %h required 00008899", last_rdata);
        end
    endtask

    task automatic test_merge_lat();
        for (int s = 0; s < 2; s++) begin
            do_req(s, 1'b1, 3'd2, 32'h0000_FFFF, 32'hAABB_CCDD);
            do_req(s, 1'b1, 3'd0, 32'h0000_FFFF, 32'h0000_0011);
            do_req(s, 1'b0, 3'd2, 32'h0000_FFFF, 32'h0);
            n_cmp++;
            if (last_rdata !== 32'hAABB_CC11) begin
                n_bad++; $display("FAIL lw_merge dut%0d: got %h required aabbcc11", s, last_rdata);
            end
        end
    endtask

    task automatic test_illegal_wrap();
        do_req(0, 1'b0, 3'd3, 32'h0000_0040, 32'h0);
        do_req(0, 1'b1, 3'd4, 32'h0000_0040, 32'h1234_5678);
        do_req(0, 1'b0, 3'd7, 32'h0000_0040, 32'h0);
        do_req(0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_7766);
        do_req(0, 1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'h0000_7766) begin
            n_bad++; $display("FAIL sh_wrap: got %h required 00007766", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        sel = 0; st = 1'b1; f3 = 3'd2; addr = 32'h0000_0300; wdata = 32'hCAFE_F00D; vld = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_ready === 1'b1) acc.push_back(c);
        end
        vld = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) ref_wr(0, 32'h300 + 32'(i), wdata[8*i +: 8]);
        n_cmp++;
        if (acc.size() != 5) begin
            n_bad++; $display("FAIL b2b_count: got %0d accepts in 15 cycles required 5", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] != 3) begin
                n_bad++; $display("FAIL b2b_interval: got %0d required 3", acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_rsp;
        sel = 0; st = 1'b1; f3 = 3'd1; addr = 32'h0000_0200; wdata = 32'h0000_1234; vld = 1'b1;
        #1;
        while (!o_ready) @(negedge clk);
        @(posedge clk); #1 vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_we !== 2'd2 || o_addr !== 32'h201) begin
            n_bad++; $display("FAIL sh_hi_phase: got en=%0d addr=%h required en=2 addr=00000201", o_we, o_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_we, o_ready, o_rsp_valid} !== {2'd0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL mid_reset: got en=%0d rdy=%0b v=%0b required en=0 rdy=1 v=0", o_we, o_ready, o_rsp_valid);
        end
        saw_rsp = 0;
        repeat (5) begin @(negedge clk); if (o_rsp_valid !== 1'b0) saw_rsp = 1; end
        n_cmp++;
        if (saw_rsp) begin
            n_bad++; $display("FAIL reset_no_rsp: got rsp_valid after reset required none");
        end
        ref_wr(0, 32'h200, 8'h34);
        ref_wr(0, 32'h201, 8'h12);
        do_req(0, 1'b1, 3'd2, 32'h0000_0200, 32'h5566_7788);
        do_req(0, 1'b0, 3'd2, 32'h0000_0200, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        pool = '{32'h0, 32'h1, 32'hFFFF, 32'hFFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h100, 32'h102};
        for (int i = 0; i < 55; i++) begin
            do_req((i < 40) ? 0 : 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 2)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stores_loads();
        test_merge_lat();
        test_illegal_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
